// File: rtl/man_frame_sched.sv
// man_frame_sched: two-requester Manchester frame scheduler.
// Builds frames of preamble (0xAA bytes), SFD (0xD5) and payload, encodes
// each byte into two 8-bit Manchester half-words, and hands one half-word
// to the serializer per slot_ce strobe. Frames are separated by a fixed
// idle gap. The owner of each frame is chosen round-robin.
module man_frame_sched #(
    parameter int PREAMBLE_LEN = 2,
    parameter int GAP_SLOTS    = 4
) (
    input  logic        clk108,
    input  logic        aresetn,
    input  logic        slot_ce,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_last,
    output logic [1:0]  req_ready,
    output logic [7:0]  word_out,
    output logic        word_valid,
    output logic [1:0]  grant,
    output logic        frame_done,
    output logic        underrun
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_PAY,
        ST_GAP
    } state_t;

    // Preamble half-words to send, counted from the one emitted on leaving IDLE.
    localparam logic [4:0] PRE_SLOTS = 5'(2 * PREAMBLE_LEN);
    // Gap counter value on the last idle slot of the gap.
    localparam logic [4:0] GAP_LAST  = 5'(GAP_SLOTS - 1);

    localparam logic [7:0] PRE_WORD  = 8'h99;  // upper/lower half of enc(0xAA)
    localparam logic [7:0] SFD_HI    = 8'hA6;  // upper half of enc(0xD5)
    localparam logic [7:0] SFD_LO    = 8'h66;  // lower half of enc(0xD5)
    localparam logic [7:0] IDLE_WORD = 8'h00;

    // Manchester encoding, MSB first: 1 -> "10", 0 -> "01".
    function automatic logic [15:0] man_encode(input logic [7:0] b);
        logic [15:0] e;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            e[2*i +: 2] = b[i] ? 2'b10 : 2'b01;
        end
        return e;
    endfunction

    // Registered state
    state_t      state_q,  state_d;
    logic [4:0]  cnt_q,    cnt_d;      // preamble or gap slot counter
    logic        half_q,   half_d;     // 0: upper half on the wire, 1: lower half
    logic [7:0]  lower_q,  lower_d;    // held lower half of the current payload byte
    logic        last_q,   last_d;     // current payload byte closes the frame
    logic [1:0]  grant_q,  grant_d;
    logic        rr_last_q, rr_d;      // requester granted most recently
    logic [7:0]  word_q,   word_d;
    logic        valid_q,  valid_d;
    logic        done_q,   done_d;
    logic        under_q,  under_d;

    // Owner-side views of the request interface
    logic        owner;
    logic        own_valid;
    logic [7:0]  own_data;
    logic        own_last;
    logic [15:0] own_enc;
    logic        pick;
    logic        at_boundary;

    assign owner     = grant_q[1];
    assign own_valid = req_valid[owner];
    assign own_data  = owner ? req_data[15:8] : req_data[7:0];
    assign own_last  = req_last[owner];
    assign own_enc   = man_encode(own_data);

    // With both requesting, prefer the one not granted last; otherwise the one asking.
    assign pick = (req_valid == 2'b11) ? ~rr_last_q : req_valid[1];

    // The slot that replaces the SFD lower half or a non-last payload lower half.
    assign at_boundary = half_q && ((state_q == ST_SFD) ||
                                    ((state_q == ST_PAY) && !last_q));

    assign req_ready  = (slot_ce && at_boundary) ? grant_q : 2'b00;
    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign grant      = grant_q;
    assign frame_done = done_q;
    assign underrun   = under_q;

    // Next-state and next-output decode; everything advances only on slot_ce.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        lower_d = lower_q;
        last_d  = last_q;
        grant_d = grant_q;
        rr_d    = rr_last_q;
        word_d  = word_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        under_d = 1'b0;

        if (slot_ce) begin
            if (at_boundary) begin
                if (own_valid) begin
                    state_d = ST_PAY;
                    half_d  = 1'b0;
                    word_d  = own_enc[15:8];
                    lower_d = own_enc[7:0];
                    last_d  = own_last;
                end else begin
                    // Owner ran dry mid-frame: abort into the gap.
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    word_d  = IDLE_WORD;
                    valid_d = 1'b0;
                    under_d = 1'b1;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        word_d  = IDLE_WORD;
                        valid_d = 1'b0;
                        if (|req_valid) begin
                            state_d = ST_PRE;
                            grant_d = pick ? 2'b10 : 2'b01;
                            rr_d    = pick;
                            cnt_d   = 5'd1;
                            word_d  = PRE_WORD;
                            valid_d = 1'b1;
                        end
                    end
                    ST_PRE: begin
                        if (cnt_q == PRE_SLOTS) begin
                            state_d = ST_SFD;
                            half_d  = 1'b0;
                            word_d  = SFD_HI;
                        end else begin
                            cnt_d  = cnt_q + 5'd1;
                            word_d = PRE_WORD;
                        end
                    end
                    ST_SFD: begin
                        // Only the upper half reaches here; the lower is a boundary.
                        half_d = 1'b1;
                        word_d = SFD_LO;
                    end
                    ST_PAY: begin
                        if (!half_q) begin
                            half_d = 1'b1;
                            word_d = lower_q;
                        end else begin
                            // Lower half of the last byte has been sent.
                            state_d = ST_GAP;
                            cnt_d   = '0;
                            word_d  = IDLE_WORD;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                    ST_GAP: begin
                        word_d  = IDLE_WORD;
                        valid_d = 1'b0;
                        if (cnt_q == GAP_LAST) begin
                            state_d = ST_IDLE;
                            grant_d = 2'b00;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        grant_d = 2'b00;
                        word_d  = IDLE_WORD;
                        valid_d = 1'b0;
                    end
                endcase
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk108 or negedge aresetn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            half_q    <= 1'b0;
            lower_q   <= '0;
            last_q    <= 1'b0;
            grant_q   <= 2'b00;
            rr_last_q <= 1'b1;  // requester 0 wins the first contested grant
            word_q    <= IDLE_WORD;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            under_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            lower_q   <= lower_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            under_q   <= under_d;
        end
    end

endmodule

// File: tb/tb_man_frame_sched.sv
// Directed testbench for man_frame_sched: default-parameter instance for
// frame, arbitration, underrun and reset scenarios; a second instance with
// PREAMBLE_LEN=1, GAP_SLOTS=1 for the short-frame and stalled-strobe case.
module tb_man_frame_sched;

    logic        clk108 = 1'b0;
    logic        aresetn;
    logic        slot_ce;

    logic [1:0]  req_valid, req_last, req_ready;
    logic [15:0] req_data;
    logic [7:0]  word_out;
    logic        word_valid, frame_done, underrun;
    logic [1:0]  grant;

    logic [1:0]  req_valid2, req_last2, req_ready2;
    logic [15:0] req_data2;
    logic [7:0]  word_out2;
    logic        word_valid2, frame_done2, underrun2;
    logic [1:0]  grant2;

    always #5 clk108 = ~clk108;

    man_frame_sched dut (
        .clk108     (clk108),
        .aresetn    (aresetn),
        .slot_ce    (slot_ce),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .grant      (grant),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    man_frame_sched #(.PREAMBLE_LEN(1), .GAP_SLOTS(1)) dut2 (
        .clk108     (clk108),
        .aresetn    (aresetn),
        .slot_ce    (slot_ce),
        .req_valid  (req_valid2),
        .req_data   (req_data2),
        .req_last   (req_last2),
        .req_ready  (req_ready2),
        .word_out   (word_out2),
        .word_valid (word_valid2),
        .grant      (grant2),
        .frame_done (frame_done2),
        .underrun   (underrun2)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Byte source for the default instance: per-requester queue of bytes.
    logic [7:0] q_data [2][8];
    logic       q_last [2][8];
    int         q_len  [2];
    int         q_idx  [2];
    int         xfer_cnt;

    // Per-slot samples
    logic [7:0] wo_s, wo2_s;
    logic       wv_s, wv2_s, fd_s, fd2_s, ur_s;
    logic [1:0] gr_s, gr2_s, rdy_s, rdy2_s, pulse_next;

    logic [7:0] exp_a [18] = '{8'h99, 8'h99, 8'h99, 8'h99, 8'hA6, 8'h66,
                               8'h99, 8'h99, 8'h9A, 8'h9A, 8'hA5, 8'hA5,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp_c [14] = '{8'h99, 8'h99, 8'h99, 8'h99, 8'hA6, 8'h66,
                               8'h66, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'h00, 8'h00};
    logic [7:0] exp_e [9]  = '{8'h99, 8'h99, 8'hA6, 8'h66, 8'h55,
                               8'h55, 8'h00, 8'h00, 8'h00};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic q_clear();
        for (int r = 0; r < 2; r++) begin
            q_len[r] = 0;
            q_idx[r] = 0;
        end
    endtask

    task automatic q_push(input int r, input logic [7:0] d, input logic l);
        q_data[r][q_len[r]] = d;
        q_last[r][q_len[r]] = l;
        q_len[r]++;
    endtask

    task automatic src_drive();
        for (int r = 0; r < 2; r++) begin
            if (q_idx[r] < q_len[r]) begin
                req_valid[r]      = 1'b1;
                req_data[8*r +: 8] = q_data[r][q_idx[r]];
                req_last[r]       = q_last[r][q_idx[r]];
            end else begin
                req_valid[r]      = 1'b0;
                req_data[8*r +: 8] = 8'h00;
                req_last[r]       = 1'b0;
            end
        end
    endtask

    // One word slot of 4 clocks, slot_ce high in the first. Entered at a negedge.
    task automatic do_slot();
        src_drive();
        slot_ce = 1'b1;
        #1;
        rdy_s  = req_ready;
        rdy2_s = req_ready2;
        @(negedge clk108);
        slot_ce = 1'b0;
        wo_s  = word_out;   wv_s  = word_valid;  gr_s  = grant;
        fd_s  = frame_done; ur_s  = underrun;
        wo2_s = word_out2;  wv2_s = word_valid2; gr2_s = grant2;
        fd2_s = frame_done2;
        for (int r = 0; r < 2; r++) begin
            if (rdy_s[r] && req_valid[r]) begin
                q_idx[r]++;
                xfer_cnt++;
            end
        end
        @(negedge clk108);
        pulse_next = {frame_done, underrun};
        repeat (2) @(negedge clk108);
    endtask

    task automatic apply_reset();
        @(negedge clk108);
        src_drive();
        slot_ce = 1'b0;
        aresetn = 1'b0;
        repeat (2) @(negedge clk108);
        aresetn  = 1'b1;
        xfer_cnt = 0;
    endtask

    initial begin
        aresetn    = 1'b0;
        slot_ce    = 1'b0;
        req_valid  = 2'b00; req_data  = 16'h0000; req_last  = 2'b00;
        req_valid2 = 2'b00; req_data2 = 16'h0000; req_last2 = 2'b00;
        xfer_cnt   = 0;
        q_clear();

        // ---- A: reset values, then one three-byte frame from requester 0
        q_push(0, 8'hAA, 1'b0);
        q_push(0, 8'hBB, 1'b0);
        q_push(0, 8'hCC, 1'b1);
        src_drive();
        repeat (3) @(negedge clk108);
        slot_ce = 1'b1;
        @(negedge clk108);
        check("rst word_out",   word_out,   16'h00);
        check("rst word_valid", word_valid, 16'h0);
        check("rst grant",      grant,      16'h0);
        check("rst req_ready",  req_ready,  16'h0);
        check("rst frame_done", frame_done, 16'h0);
        check("rst underrun",   underrun,   16'h0);
        slot_ce  = 1'b0;
        aresetn  = 1'b1;
        xfer_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            do_slot();
            check($sformatf("A word_out[%0d]", i),   wo_s,  exp_a[i]);
            check($sformatf("A word_valid[%0d]", i), wv_s,  (i < 12) ? 16'h1 : 16'h0);
            check($sformatf("A grant[%0d]", i),      gr_s,  (i < 16) ? 16'h1 : 16'h0);
            check($sformatf("A req_ready[%0d]", i),  rdy_s, (i == 6 || i == 8 || i == 10) ? 16'h1 : 16'h0);
            check($sformatf("A frame_done[%0d]", i), fd_s,  (i == 12) ? 16'h1 : 16'h0);
            check($sformatf("A underrun[%0d]", i),   ur_s,  16'h0);
            check($sformatf("A pulse_next[%0d]", i), pulse_next, 16'h0);
        end
        check("A transfers", xfer_cnt, 16'd3);

        // ---- B: both requesters valid from reset; grants alternate 01,10,01
        q_clear();
        q_push(0, 8'h11, 1'b1);
        q_push(0, 8'h22, 1'b1);
        q_push(1, 8'h33, 1'b1);
        q_push(1, 8'h44, 1'b1);
        apply_reset();
        for (int i = 0; i < 27; i++) begin
            do_slot();
            if (i == 0)  check("B grant first",  gr_s, 16'h1);
            if (i == 6)  check("B rdy req0 only", rdy_s, 16'h1);
            if (i == 6)  check("B word_out 11 hi", wo_s, 16'h56);
            if (i == 7)  check("B word_out 11 lo", wo_s, 16'h56);
            if (i == 8)  check("B frame_done 1", fd_s, 16'h1);
            if (i == 12) check("B grant idle", gr_s, 16'h0);
            if (i == 13) check("B grant second", gr_s, 16'h2);
            if (i == 19) check("B rdy req1 only", rdy_s, 16'h2);
            if (i == 19) check("B word_out 33 hi", wo_s, 16'h5A);
            if (i == 20) check("B word_out 33 lo", wo_s, 16'h5A);
            if (i == 21) check("B frame_done 2", fd_s, 16'h1);
            if (i == 26) check("B grant third", gr_s, 16'h1);
        end

        // ---- C: requester 1 drops valid at its second byte boundary
        q_clear();
        q_push(1, 8'h5A, 1'b0);
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            do_slot();
            check($sformatf("C word_out[%0d]", i),   wo_s,  exp_c[i]);
            check($sformatf("C word_valid[%0d]", i), wv_s,  (i < 8) ? 16'h1 : 16'h0);
            check($sformatf("C grant[%0d]", i),      gr_s,  (i < 12) ? 16'h2 : 16'h0);
            check($sformatf("C req_ready[%0d]", i),  rdy_s, (i == 6 || i == 8) ? 16'h2 : 16'h0);
            check($sformatf("C underrun[%0d]", i),   ur_s,  (i == 8) ? 16'h1 : 16'h0);
            check($sformatf("C frame_done[%0d]", i), fd_s,  16'h0);
            check($sformatf("C pulse_next[%0d]", i), pulse_next, 16'h0);
        end
        check("C transfers", xfer_cnt, 16'd1);

        // ---- D: reset asserted during PAY, then restart from preamble
        q_clear();
        q_push(0, 8'hAA, 1'b0);
        q_push(0, 8'hBB, 1'b0);
        q_push(0, 8'hCC, 1'b1);
        apply_reset();
        for (int i = 0; i < 8; i++) do_slot();
        check("D in PAY word_out", wo_s, 16'h99);
        src_drive();
        slot_ce = 1'b1;
        #1;
        check("D boundary ready", req_ready, 16'h1);
        aresetn = 1'b0;
        #1;
        check("D rst word_out",   word_out,   16'h00);
        check("D rst word_valid", word_valid, 16'h0);
        check("D rst grant",      grant,      16'h0);
        check("D rst req_ready",  req_ready,  16'h0);
        @(negedge clk108);
        check("D rst hold word_out", word_out,   16'h00);
        check("D rst hold fd/ur",    {frame_done, underrun}, 16'h0);
        slot_ce = 1'b0;
        aresetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_slot();
            check($sformatf("D word_out[%0d]", i),   wo_s, (i < 4) ? 16'h99 : (i == 4) ? 16'hA6 : 16'h66);
            check($sformatf("D word_valid[%0d]", i), wv_s, 16'h1);
            check($sformatf("D grant[%0d]", i),      gr_s, 16'h1);
        end

        // ---- E: PREAMBLE_LEN=1, GAP_SLOTS=1, single byte 0x00, stalled strobe
        q_clear();
        apply_reset();
        req_valid2 = 2'b01;
        req_data2  = 16'h0000;
        req_last2  = 2'b01;
        for (int i = 0; i < 9; i++) begin
            do_slot();
            if (rdy2_s[0]) req_valid2 = 2'b00;
            check($sformatf("E word_out[%0d]", i),   wo2_s, exp_e[i]);
            check($sformatf("E word_valid[%0d]", i), wv2_s, (i < 6) ? 16'h1 : 16'h0);
            check($sformatf("E grant[%0d]", i),      gr2_s, (i < 7) ? 16'h1 : 16'h0);
            check($sformatf("E req_ready[%0d]", i),  rdy2_s, (i == 4) ? 16'h1 : 16'h0);
            check($sformatf("E frame_done[%0d]", i), fd2_s, (i == 6) ? 16'h1 : 16'h0);
            if (i == 4) begin
                // Ten cycles with no strobe while other inputs churn.
                req_valid2 = 2'b11;
                req_data2  = 16'hFFFF;
                req_last2  = 2'b00;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk108);
                    check($sformatf("E hold word_out[%0d]", k),   word_out2,   16'h55);
                    check($sformatf("E hold word_valid[%0d]", k), word_valid2, 16'h1);
                    check($sformatf("E hold grant[%0d]", k),      grant2,      16'h1);
                    check($sformatf("E hold req_ready[%0d]", k),  req_ready2,  16'h0);
                end
                req_valid2 = 2'b00;
                req_data2  = 16'h0000;
                req_last2  = 2'b00;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/man_frame_sched.md
MAN_FRAME_SCHED -- requirements
Module: man_frame_sched

Interface
REQ-001 SHALL have parameter PREAMBLE_LEN, default 2, number of 0xAA preamble bytes per frame (range 1..15).
REQ-002 SHALL have parameter GAP_SLOTS, default 4, number of idle word slots after each frame (range 1..15).
REQ-003 SHALL have port clk108  in  1  fast clock; all logic is on its rising edge.
REQ-004 SHALL have port aresetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port slot_ce  in  1  one-cycle strobe per serializer word slot (one slot = 8 serial bits).
REQ-006 SHALL have port req_valid  in  2  per-requester byte valid.
REQ-007 SHALL have port req_data  in  16  requester r byte on bits [8r+7:8r].
REQ-008 SHALL have port req_last  in  2  per-requester last-byte-of-frame flag.
REQ-009 SHALL have port req_ready  out  2  per-requester byte accept; a transfer occurs when valid and ready are both 1.
REQ-010 SHALL have port word_out  out  8  Manchester half-word to the serializer, MSB sent first.
REQ-011 SHALL have port word_valid  out  1  1 while word_out carries frame content.
REQ-012 SHALL have port grant  out  2  one-hot owner of the current frame; 0 when no frame is in progress.
REQ-013 SHALL have port frame_done  out  1  one-cycle pulse on normal frame completion.
REQ-014 SHALL have port underrun  out  1  one-cycle pulse on frame abort.

Function
REQ-015 Each byte SHALL be encoded as 16 bits, MSB first: bit 1 -> "10", bit 0 -> "01". Examples: 0xAA -> 0x9999; 0xD5 -> 0xA666.
REQ-016 Each byte SHALL occupy two consecutive slots: the upper encoded half first, then the lower half.
REQ-017 word_out, word_valid, grant and the state SHALL change only on clk108 edges where slot_ce=1, with registered outputs visible the next cycle.
REQ-018 The state machine SHALL have states IDLE, PRE, SFD, PAY and GAP.
REQ-019 In IDLE and GAP, word_out SHALL be 0x00 and word_valid SHALL be 0.
REQ-020 In IDLE, on a slot_ce where any req_valid=1, the block SHALL select a requester round-robin, preferring the requester not granted last, and SHALL go to PRE.
REQ-021 In IDLE, on that same slot_ce, the block SHALL load grant and output the first preamble half (0x99) with word_valid=1.
REQ-022 Arbitration history after reset SHALL favour requester 0.
REQ-023 grant SHALL stay fixed until the frame ends; the other requester's valid SHALL be ignored until then.
REQ-024 PRE SHALL output 0x99 for 2*PREAMBLE_LEN slots.
REQ-025 SFD SHALL then output 0xA6 followed by 0x66.
REQ-026 A byte boundary SHALL be the slot_ce on which the second half of an SFD or a non-last PAY byte is being replaced.
REQ-027 At a byte boundary, req_ready[grant] SHALL equal slot_ce, combinationally from registered state; req_ready SHALL be 0 at all other times and for the non-granted requester.
REQ-028 On a transfer, word_out SHALL take the upper encoded half of req_data, the lower half SHALL be held for the next slot, and the state SHALL be PAY.
REQ-029 req_last SHALL be captured with the byte it accompanies.
REQ-030 After the lower half of a byte with last=1, the state SHALL go to GAP and frame_done SHALL pulse.
REQ-031 At a byte boundary with req_valid[grant]=0, the block SHALL pulse underrun, set word_valid=0 and word_out=0x00 for that slot, and go to GAP.
REQ-032 GAP SHALL last exactly GAP_SLOTS slots, then go to IDLE with grant cleared.
REQ-033 A request already pending when GAP ends SHALL be granted on the first slot_ce in IDLE.
REQ-034 If slot_ce=0, nothing SHALL change, regardless of the other inputs.
REQ-035 There SHALL be no limit on frame length.

Reset
REQ-036 While aresetn=0, the block SHALL hold state IDLE, word_out=0x00, word_valid=0, grant=0, req_ready=0, frame_done=0 and underrun=0, with round-robin pointer favouring requester 0; assertion mid-frame SHALL abort immediately with no further outputs.
REQ-037 Operation SHALL resume on the first slot_ce after release.

Verification
REQ-038 slot_ce every 4th cycle; req0 sends 0xAA,0xBB,0xCC(last) -> word_out 99,99,99,99,A6,66,99,99,9A,9A,A5,A5, then 0x00 for 4 slots; frame_done once; grant=01 throughout.
REQ-039 req0 and req1 both valid from reset -> req0 frame first, then req1 after the gap; with both still valid, grants alternate 01,10,01.
REQ-040 req1 deasserts valid at its second byte boundary -> underrun pulses, exactly 1 payload byte sent, GAP of 4 slots, then IDLE.
REQ-041 aresetn pulsed low during PAY -> outputs reset within the same cycle, req_ready=0; a new frame restarts from preamble.
REQ-042 PREAMBLE_LEN=1, GAP_SLOTS=1, single-byte frame 0x00 -> 99,99,A6,66,55,55, one idle slot; slot_ce held low for 10 cycles mid-frame causes no change to word_out.
